// File: rtl/palindrome_control.sv
// Control FSM for the palindrome datapath: walks front/back pointers inward and reports pass/fail.
// Optional iteration timeout is built when PAL_TIMEOUT_EN is defined.
module palindrome_control #(
   parameter int MAX_ITERS = 16,
   parameter int CNT_W     = 5
) (
   input  logic clock,
   input  logic reset,
   input  logic go,
   input  logic front_ge_back,
   input  logic a_ne_b,
   output logic ld,
   output logic sel,
   output logic done,
   output logic palindrome
`ifdef PAL_TIMEOUT_EN
   ,
   output logic timeout
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, PASS, FAIL} state_t;

   state_t state, next_state;
   logic   to_hit;

   if (MAX_ITERS > (2**CNT_W) - 1) begin : g_param_chk
      $error("MAX_ITERS does not fit in CNT_W bits");
   end

`ifdef PAL_TIMEOUT_EN
   logic [CNT_W-1:0] iter;
`endif

   always_comb begin
      next_state = state;
      ld         = 1'b0;
      sel        = 1'b0;
      to_hit     = 1'b0;
      case (state)
         IDLE: if (go) next_state = LOAD;
         LOAD: begin
            ld         = 1'b1;
            next_state = CHECK;
         end
         CHECK: begin
            // Crossing beats mismatch so an odd middle element compares with itself and passes.
            if (front_ge_back)  next_state = PASS;
            else if (a_ne_b)    next_state = FAIL;
`ifdef PAL_TIMEOUT_EN
            else if (iter == CNT_W'(MAX_ITERS)) begin
               next_state = FAIL;
               to_hit     = 1'b1;
            end
`endif
            else begin
               ld  = 1'b1;
               sel = 1'b1;
            end
         end
         PASS, FAIL: if (go) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         done       <= 1'b0;
         palindrome <= 1'b0;
      end else begin
         state      <= next_state;
         done       <= (next_state == PASS) || (next_state == FAIL);
         palindrome <= (next_state == PASS);
      end
   end

`ifdef PAL_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         iter    <= '0;
         timeout <= 1'b0;
      end else begin
         if (state == LOAD)              iter <= '0;
         else if (state == CHECK && ld)  iter <= iter + 1'b1;
         if (next_state == LOAD)         timeout <= 1'b0;
         else if (to_hit)                timeout <= 1'b1;
      end
   end
`else
   logic unused_to;
   assign unused_to = to_hit;
`endif

endmodule

// File: tb/tb_palindrome_control.sv
// Directed bench for palindrome_control with a behavioural pointer/register-file datapath.
module tb_palindrome_control;

   logic clock = 1'b0;
   logic reset, go;
   logic ld, sel, done, palindrome;
   logic front_ge_back, a_ne_b;
   logic [31:0] rf [32];
   logic [4:0]  base, ending, front, back;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign front_ge_back = (front >= back);
   assign a_ne_b        = (rf[front] != rf[back]);

   always @(posedge clock)
      if (ld) begin
         front <= sel ? front + 5'd1 : base;
         back  <= sel ? back  - 5'd1 : ending;
      end

`ifdef PAL_TIMEOUT_EN
   logic timeout;
   logic go2, ld2, sel2, done2, pal2, timeout2;
   logic [4:0] front2, back2;

   palindrome_control dut (
      .clock(clock), .reset(reset), .go(go), .front_ge_back(front_ge_back), .a_ne_b(a_ne_b),
      .ld(ld), .sel(sel), .done(done), .palindrome(palindrome), .timeout(timeout));

   palindrome_control #(.MAX_ITERS(1)) dut_to (
      .clock(clock), .reset(reset), .go(go2), .front_ge_back(front2 >= back2),
      .a_ne_b(rf[front2] != rf[back2]),
      .ld(ld2), .sel(sel2), .done(done2), .palindrome(pal2), .timeout(timeout2));

   always @(posedge clock)
      if (ld2) begin
         front2 <= sel2 ? front2 + 5'd1 : base;
         back2  <= sel2 ? back2  - 5'd1 : ending;
      end
`else
   palindrome_control dut (
      .clock(clock), .reset(reset), .go(go), .front_ge_back(front_ge_back), .a_ne_b(a_ne_b),
      .ld(ld), .sel(sel), .done(done), .palindrome(palindrome));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // edges counts from the edge that samples go to the edge where done becomes visible
   task automatic run(input string tag, input logic [4:0] b, input logic [4:0] e,
                      input int edges, input logic exp_pal);
      base = b; ending = e; go = 1'b1;
      step(1);
      go = 1'b0;
      chk({tag, "_load_done"}, done, 0);
      chk({tag, "_load_ld"}, ld, 1);
      chk({tag, "_load_sel"}, sel, 0);
      step(edges - 2);
      chk({tag, "_early_done"}, done, 0);
      step(1);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_pal"}, palindrome, exp_pal);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[11] = 32'h12344321; rf[12] = 32'h0; rf[13] = 32'h0; rf[14] = 32'h12344321;
      rf[2] = 32'hCAFEBABE; rf[3] = 32'hFFFFFFFF; rf[4] = 32'h0B3D1E55;
      rf[5] = 32'hFFFFFFFF; rf[6] = 32'hCAFEBABE;
      rf[7] = 32'h33333333; rf[8] = 32'hC001D0D3; rf[9] = 32'hFFFFFFFF;
      rf[10] = 32'hBAB3D0D3;
      // rf[11] is shared with the even test; the mismatch span ends on a matching value
      rf[11] = 32'h12344321;
      front = 5'd0; back = 5'd0; base = 5'd0; ending = 5'd0;
`ifdef PAL_TIMEOUT_EN
      go2 = 1'b0; front2 = 5'd0; back2 = 5'd0;
`endif
      reset = 1'b1; go = 1'b0;
      step(2);
      reset = 1'b0;
      chk("rst_done", done, 0);
      chk("rst_pal", palindrome, 0);
      chk("rst_ld", ld, 0);
      step(3);
      chk("idle_hold_done", done, 0);

      run("even", 5'd11, 5'd14, 5, 1'b1);
      run("odd", 5'd2, 5'd6, 5, 1'b1);
      // mismatch test uses r7..r11 with r11 = 33333333
      rf[11] = 32'h33333333;
      run("mism", 5'd7, 5'd11, 4, 1'b0);
      rf[11] = 32'h12344321;
      run("single", 5'd20, 5'd20, 3, 1'b1);
      run("crossed", 5'd9, 5'd3, 3, 1'b1);

      // reset in PASS clears outputs
      reset = 1'b1; step(1); reset = 1'b0;
      chk("rst_pass_done", done, 0);
      chk("rst_pass_pal", palindrome, 0);

      // reset during CHECK of the odd test
      base = 5'd2; ending = 5'd6; go = 1'b1;
      step(1); go = 1'b0;
      step(1);
      chk("chk_adv_ld", ld, 1);
      chk("chk_adv_sel", sel, 1);
      reset = 1'b1; step(1); reset = 1'b0;
      chk("rst_mid_done", done, 0);
      chk("rst_mid_ld", ld, 0);
      step(2);
      chk("rst_mid_idle", done, 0);
      run("odd_rerun", 5'd2, 5'd6, 5, 1'b1);

`ifdef PAL_TIMEOUT_EN
      chk("to_main_clear", timeout, 0);
      base = 5'd11; ending = 5'd14; go2 = 1'b1;
      step(1); go2 = 1'b0;
      chk("to_load_to", timeout2, 0);
      step(2);
      chk("to_early_done", done2, 0);
      step(1);
      chk("to_done", done2, 1);
      chk("to_pal", pal2, 0);
      chk("to_flag", timeout2, 1);
      go2 = 1'b1; step(1); go2 = 1'b0;
      chk("to_clear", timeout2, 0);
      chk("to_clear_done", done2, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
